// File: rtl/nibble_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_deserializer
//  Purpose  : Assembles a serial bit stream into WIDTH-bit nibbles and buffers
//             them in a DEPTH-entry FIFO, presented on a valid/ready interface
//             that feeds the 4-bit bit-manipulation datapath.
//  Ports    :
//    clk          in   single clock, rising edge
//    rst          in   synchronous active-high reset
//    bit_in       in   serial data bit
//    bit_valid    in   bit_in valid this cycle
//    bit_ready    out  bit accepted this cycle (combinational)
//    flush        in   discard the partially assembled nibble
//    nib_out      out  head-of-FIFO nibble (0 when empty)
//    nib_valid    out  FIFO non-empty
//    nib_ready    in   consumer takes nib_out this cycle
//    fill_level   out  registered FIFO occupancy
//    partial_drop out  one-cycle pulse after a flush discarded bits
//  Revision : 1.0  initial release
// ============================================================================
module nibble_deserializer #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    output logic                       bit_ready,
    input  logic                       flush,
    output logic [WIDTH-1:0]           nib_out,
    output logic                       nib_valid,
    input  logic                       nib_ready,
    output logic [$clog2(DEPTH+1)-1:0] fill_level,
    output logic                       partial_drop
);

    localparam int CNT_W  = $clog2(WIDTH);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = $clog2(DEPTH+1);

    localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(WIDTH-1);
    localparam logic [FILL_W-1:0] C_FILL_MAX = FILL_W'(DEPTH);

    // Assembly state
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic              pdrop_q, pdrop_d;

    // FIFO state
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    logic              w_bit_acc;
    logic              w_pop;
    logic              w_push;
    logic              w_last;
    logic              w_full;
    logic [WIDTH-1:0]  w_nib_next;

    // Shift register contents once the incoming bit is inserted; on the
    // completing bit this is the finished nibble written into the FIFO.
    if (MSB_FIRST) begin : g_msb_first
        assign w_nib_next = (sr_q << 1) | WIDTH'(bit_in);
    end else begin : g_lsb_first
        assign w_nib_next = (sr_q >> 1) | (WIDTH'(bit_in) << (WIDTH-1));
    end

    assign nib_valid  = (fill_q != '0);
    assign nib_out    = nib_valid ? mem_q[rd_ptr_q] : '0;
    assign fill_level = fill_q;
    assign partial_drop = pdrop_q;

    assign w_pop  = nib_valid & nib_ready;
    assign w_last = (cnt_q == C_CNT_LAST);
    assign w_full = (fill_q == C_FILL_MAX);

    // Only the completing bit can overflow the FIFO, and a same-cycle pop
    // frees the slot it needs, hence the combinational nib_ready term.
    assign bit_ready = !rst && !flush && !(w_last && w_full && !w_pop);
    assign w_bit_acc = bit_valid & bit_ready;
    assign w_push    = w_bit_acc & w_last;

    always_comb begin
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        pdrop_d  = 1'b0;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;

        if (flush) begin
            cnt_d   = '0;
            sr_d    = '0;
            pdrop_d = (cnt_q != '0);
        end else if (w_bit_acc) begin
            if (w_last) begin
                cnt_d = '0;
                sr_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                sr_d  = w_nib_next;
            end
        end

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({w_push, w_pop})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            sr_q     <= '0;
            pdrop_q  <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            pdrop_q  <= pdrop_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage needs no reset: entries are only visible while fill_q covers them.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            mem_q[wr_ptr_q] <= w_nib_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nibble_deserializer
//  Purpose  : Directed self-checking bench for nibble_deserializer, with one
//             MSB-first instance and one LSB-first instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nibble_deserializer;

    logic       clk = 1'b0;
    logic       rst;
    // MSB-first instance
    logic       bit_in, bit_valid, flush, nib_ready;
    logic       bit_ready, nib_valid, partial_drop;
    logic [3:0] nib_out;
    logic [1:0] fill_level;
    // LSB-first instance
    logic       l_bit_in, l_bit_valid, l_flush, l_nib_ready;
    logic       l_bit_ready, l_nib_valid, l_partial_drop;
    logic [3:0] l_nib_out;
    logic [1:0] l_fill_level;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nibble_deserializer #(.WIDTH(4), .DEPTH(2), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .flush(flush), .nib_out(nib_out),
        .nib_valid(nib_valid), .nib_ready(nib_ready),
        .fill_level(fill_level), .partial_drop(partial_drop)
    );

    nibble_deserializer #(.WIDTH(4), .DEPTH(2), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .bit_in(l_bit_in), .bit_valid(l_bit_valid),
        .bit_ready(l_bit_ready), .flush(l_flush), .nib_out(l_nib_out),
        .nib_valid(l_nib_valid), .nib_ready(l_nib_ready),
        .fill_level(l_fill_level), .partial_drop(l_partial_drop)
    );

    // Advance one clock; inputs change and checks happen 1-2 time units
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; l_bit_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (bit_ready !== 1'b0) begin n_bad++; $display("FAIL rst_bit_ready: got %b want 0", bit_ready); end
            n_vec++; if (l_bit_ready !== 1'b0) begin n_bad++; $display("FAIL rst_l_bit_ready: got %b want 0", l_bit_ready); end
            tick();
        end
        rst = 1'b0; bit_valid = 1'b0; l_bit_valid = 1'b0;
        tick();
        n_vec++; if (nib_valid !== 1'b0) begin n_bad++; $display("FAIL rst_nib_valid: got %b want 0", nib_valid); end
        n_vec++; if (fill_level !== 2'd0) begin n_bad++; $display("FAIL rst_fill: got %0d want 0", fill_level); end
        n_vec++; if (nib_out !== 4'h0) begin n_bad++; $display("FAIL rst_nib_out: got %h want 0", nib_out); end
        n_vec++; if (partial_drop !== 1'b0) begin n_bad++; $display("FAIL rst_pdrop: got %b want 0", partial_drop); end
        n_vec++; if (l_fill_level !== 2'd0) begin n_bad++; $display("FAIL rst_l_fill: got %0d want 0", l_fill_level); end
    endtask

    task automatic test_single();
        logic [3:0] v;
        v = 4'hB;
        nib_ready = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            bit_in = v[i]; bit_valid = 1'b1;
            #1;
            n_vec++; if (bit_ready !== 1'b1) begin n_bad++; $display("FAIL single_bit_ready[%0d]: got %b want 1", i, bit_ready); end
            tick();
        end
        bit_valid = 1'b0;
        n_vec++; if (nib_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", nib_valid); end
        n_vec++; if (nib_out !== 4'hB) begin n_bad++; $display("FAIL single_nib: got %h want b", nib_out); end
        n_vec++; if (fill_level !== 2'd1) begin n_bad++; $display("FAIL single_fill: got %0d want 1", fill_level); end
        tick();
        n_vec++; if (nib_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_drop: got %b want 0", nib_valid); end
        n_vec++; if (fill_level !== 2'd0) begin n_bad++; $display("FAIL single_fill_drain: got %0d want 0", fill_level); end
        nib_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [11:0] s;
        s = 12'hA5F;
        nib_ready = 1'b0;
        for (int i = 11; i >= 1; i--) begin
            bit_in = s[i]; bit_valid = 1'b1;
            #1;
            n_vec++; if (bit_ready !== 1'b1) begin n_bad++; $display("FAIL bp_bit_ready[%0d]: got %b want 1", i, bit_ready); end
            tick();
            if (i == 4) begin
                n_vec++; if (fill_level !== 2'd2) begin n_bad++; $display("FAIL bp_fill8: got %0d want 2", fill_level); end
            end
        end
        // 12th bit must stall: FIFO full, completing bit, no pop
        bit_in = s[0]; bit_valid = 1'b1;
        #1;
        n_vec++; if (bit_ready !== 1'b0) begin n_bad++; $display("FAIL bp_stall: got %b want 0", bit_ready); end
        tick();
        n_vec++; if (fill_level !== 2'd2) begin n_bad++; $display("FAIL bp_stall_fill: got %0d want 2", fill_level); end
        n_vec++; if (nib_out !== 4'hA) begin n_bad++; $display("FAIL bp_stable_nib: got %h want a", nib_out); end
        n_vec++; if (nib_valid !== 1'b1) begin n_bad++; $display("FAIL bp_stable_valid: got %b want 1", nib_valid); end
        nib_ready = 1'b1;
        #1;
        n_vec++; if (bit_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %b want 1", bit_ready); end
        tick();
        bit_valid = 1'b0;
        n_vec++; if (fill_level !== 2'd2) begin n_bad++; $display("FAIL bp_pushpop_fill: got %0d want 2", fill_level); end
        n_vec++; if (nib_out !== 4'h5) begin n_bad++; $display("FAIL bp_pop2: got %h want 5", nib_out); end
        tick();
        n_vec++; if (fill_level !== 2'd1) begin n_bad++; $display("FAIL bp_fill1: got %0d want 1", fill_level); end
        n_vec++; if (nib_out !== 4'hF) begin n_bad++; $display("FAIL bp_pop3: got %h want f", nib_out); end
        tick();
        n_vec++; if (nib_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got %b want 0", nib_valid); end
        n_vec++; if (fill_level !== 2'd0) begin n_bad++; $display("FAIL bp_fill0: got %0d want 0", fill_level); end
        nib_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic [3:0] v;
        nib_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bit_in = 1'b1; bit_valid = 1'b1;
            tick();
        end
        // flush wins over a valid bit
        flush = 1'b1; bit_in = 1'b1; bit_valid = 1'b1;
        #1;
        n_vec++; if (bit_ready !== 1'b0) begin n_bad++; $display("FAIL flush_bit_ready: got %b want 0", bit_ready); end
        n_vec++; if (partial_drop !== 1'b0) begin n_bad++; $display("FAIL flush_pdrop_early: got %b want 0", partial_drop); end
        tick();
        bit_valid = 1'b0;
        n_vec++; if (partial_drop !== 1'b1) begin n_bad++; $display("FAIL flush_pdrop: got %b want 1", partial_drop); end
        // second flush with nothing buffered: no pulse
        tick();
        flush = 1'b0;
        n_vec++; if (partial_drop !== 1'b0) begin n_bad++; $display("FAIL flush_pdrop_once: got %b want 0", partial_drop); end
        tick();
        n_vec++; if (partial_drop !== 1'b0) begin n_bad++; $display("FAIL flush_empty_nopulse: got %b want 0", partial_drop); end
        v = 4'h6;
        for (int i = 3; i >= 0; i--) begin
            bit_in = v[i]; bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        n_vec++; if (nib_out !== 4'h6) begin n_bad++; $display("FAIL flush_after_nib: got %h want 6", nib_out); end
        n_vec++; if (fill_level !== 2'd1) begin n_bad++; $display("FAIL flush_after_fill: got %0d want 1", fill_level); end
        nib_ready = 1'b1;
        tick();
        nib_ready = 1'b0;
        n_vec++; if (fill_level !== 2'd0) begin n_bad++; $display("FAIL flush_drain: got %0d want 0", fill_level); end
    endtask

    task automatic test_lsb_first();
        logic [7:0] s;
        s = 8'b1000_0001;
        l_nib_ready = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            l_bit_in = s[i]; l_bit_valid = 1'b1;
            tick();
        end
        l_bit_valid = 1'b0;
        n_vec++; if (l_fill_level !== 2'd2) begin n_bad++; $display("FAIL lsb_fill: got %0d want 2", l_fill_level); end
        n_vec++; if (l_nib_out !== 4'h1) begin n_bad++; $display("FAIL lsb_nib1: got %h want 1", l_nib_out); end
        l_nib_ready = 1'b1;
        tick();
        n_vec++; if (l_nib_out !== 4'h8) begin n_bad++; $display("FAIL lsb_nib2: got %h want 8", l_nib_out); end
        tick();
        l_nib_ready = 1'b0;
        n_vec++; if (l_fill_level !== 2'd0) begin n_bad++; $display("FAIL lsb_drain: got %0d want 0", l_fill_level); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] s;
        logic [3:0] v;
        s = 10'b0011_1100_10;
        nib_ready = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            bit_in = s[i]; bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        n_vec++; if (fill_level !== 2'd2) begin n_bad++; $display("FAIL rmid_pre_fill: got %0d want 2", fill_level); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (fill_level !== 2'd0) begin n_bad++; $display("FAIL rmid_fill: got %0d want 0", fill_level); end
        n_vec++; if (nib_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %b want 0", nib_valid); end
        n_vec++; if (nib_out !== 4'h0) begin n_bad++; $display("FAIL rmid_nib: got %h want 0", nib_out); end
        n_vec++; if (partial_drop !== 1'b0) begin n_bad++; $display("FAIL rmid_pdrop: got %b want 0", partial_drop); end
        // a stale bit count would complete a nibble after only two bits
        v = 4'h3;
        for (int i = 3; i >= 0; i--) begin
            bit_in = v[i]; bit_valid = 1'b1;
            tick();
            if (i == 2) begin
                n_vec++; if (nib_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_cnt_cleared: got %b want 0", nib_valid); end
            end
        end
        bit_valid = 1'b0;
        n_vec++; if (nib_out !== 4'h3) begin n_bad++; $display("FAIL rmid_nib3: got %h want 3", nib_out); end
        n_vec++; if (fill_level !== 2'd1) begin n_bad++; $display("FAIL rmid_fill1: got %0d want 1", fill_level); end
        n_vec++; if (partial_drop !== 1'b0) begin n_bad++; $display("FAIL rmid_pdrop2: got %b want 0", partial_drop); end
    endtask

    initial begin
        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; flush = 1'b0; nib_ready = 1'b0;
        l_bit_in = 1'b0; l_bit_valid = 1'b0; l_flush = 1'b0; l_nib_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_backpressure();
        test_flush();
        test_lsb_first();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/nibble_deserializer.md
Name: nibble_deserializer

Overview:
- Upstream feeder for the 4-bit bit-manipulation datapath (the reuse/invert/reduce chain).
- Collects a serial bit stream into WIDTH-bit nibbles and buffers them in a DEPTH-entry FIFO.
- Presents nibbles on a valid/ready interface whose data bus drives the datapath's `in` input.
- Gives the combinational chain a clocked, back-pressured stimulus source, so it can be exercised under sequential conditions in the circuit flow.

Parameters:
- WIDTH, 4, nibble width in bits; must match the downstream `in` bus.
- DEPTH, 2, FIFO entries (power of two, >= 2).
- MSB_FIRST, 1, 1: first accepted bit lands in bit WIDTH-1; 0: first accepted bit lands in bit 0.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  block accepts bit_in this cycle; combinational.
- flush  input  1  discard the partially assembled nibble.
- nib_out  output  WIDTH  head-of-FIFO nibble.
- nib_valid  output  1  FIFO non-empty.
- nib_ready  input  1  consumer takes nib_out this cycle.
- fill_level  output  clog2(DEPTH+1)  registered FIFO occupancy.
- partial_drop  output  1  one-cycle pulse: flush discarded at least 1 bit.

Behaviour:
- Reset (rst=1 at an edge):
  - Shift register and bit count are set to 0.
  - FIFO is emptied; pointers go to 0.
  - nib_out=0, nib_valid=0, fill_level=0, partial_drop=0.
  - bit_ready is low while rst=1.
  - Reset mid-operation discards all buffered and partial data. No output pulses are generated for the discarded data.
- Transfer rules:
  - A bit is accepted when bit_valid & bit_ready.
  - A nibble is popped when nib_valid & nib_ready.
- Bit accumulation:
  - cnt counts 0..WIDTH-1 and increments on each accepted bit.
  - MSB_FIRST=1: the shift register shifts left, inserting at the LSB.
  - MSB_FIRST=0: the shift register shifts right, inserting at the MSB.
- Nibble completion:
  - Accepting a bit with cnt==WIDTH-1 writes the completed nibble, including this bit, into the FIFO tail at that edge.
  - At the same edge, cnt returns to 0 and the shift register is cleared.
  - Latency: nib_valid rises the cycle after the WIDTH-th bit is accepted, if the FIFO was empty.
- FIFO:
  - nib_out is driven from the head entry and is 0 when the FIFO is empty.
  - Push with simultaneous pop: allowed at any fill level, including full. fill_level is unchanged.
  - Push without pop: fill_level +1. Pop without push: fill_level -1.
  - Pointers wrap modulo DEPTH.
  - nib_out and nib_valid must remain stable while nib_valid=1 and nib_ready=0.
- bit_ready:
  - bit_ready = !rst & !flush & !(cnt==WIDTH-1 & fill_level==DEPTH & !(nib_valid & nib_ready)).
  - This gives a combinational path from nib_ready to bit_ready; this path is intentional.
  - Bits are never dropped. bit_ready falls only when the completing bit would overflow the FIFO.
- Flush:
  - flush=1 has priority over an incoming bit; no bit is accepted that cycle.
  - Flush clears cnt and the shift register.
  - Flush does not touch the FIFO; pops continue normally during a flush cycle.
  - partial_drop is registered: it goes high the cycle after a flush with cnt!=0, for exactly one cycle.
  - Flush with cnt==0 produces no pulse.
  - Repeated flush cycles pulse only when bits are actually discarded.
- Behavioural states, implied by cnt and fill_level:
  - EMPTY: cnt=0, fill=0.
  - FILLING: cnt>0.
  - BUFFERED: fill>0.
  - STALLED: cnt=WIDTH-1, fill=DEPTH, no pop; bit_ready=0.

Test Plan:
- rst held 3 cycles with bit_valid=1 -> bit_ready=0. After release: nib_valid=0, fill_level=0, nib_out=0, partial_drop=0.
- nib_ready=1; bits 1,0,1,1 on consecutive cycles (MSB_FIRST=1) -> the cycle after the 4th bit: nib_out=4'hB, nib_valid=1 for exactly one cycle, fill_level returns to 0.
- nib_ready=0; stream 0xA, 0x5, then 0xF MSB-first:
  - fill_level=2 after 8 bits.
  - bit_ready=0 after the 11th bit is accepted (12th stalled).
  - Raise nib_ready -> pops 0xA, then 0x5, then 0xF in order.
  - 12th bit accepted in the same cycle as the first pop.
- Bits 1,1; flush=1 for one cycle -> partial_drop=1 the next cycle only. Then bits 0,1,1,0 -> nib_out=4'h6.
- MSB_FIRST=0; bits 1,0,0,0 -> nib_out=4'h1. Bits 0,0,0,1 -> nib_out=4'h8.
- fill_level=2 with cnt=2; assert rst for one cycle -> next cycle: fill_level=0, nib_valid=0, cnt=0, no partial_drop pulse. Following nibble 0x3 emerges correctly.
